// File: rtl/iterative_shifter_if.sv
// Request/result bundle between the operand source, the shifter and the ALU result mux.
interface iterative_shifter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [AMT_W-1:0] amt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Y;
   logic             OF;

   // Requester side
   modport master (
      output start, op, A, amt,
      input  busy, done, Y, OF
   );

   // Shifter side
   modport slave (
      input  start, op, A, amt,
      output busy, done, Y, OF
   );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle variable-amount shifter: one bit of shift per clock until the
// requested amount is consumed, then a one-cycle done pulse with Y/OF valid.
module iterative_shifter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   iterative_shifter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic [1:0] OpLls = 2'b00;
   localparam logic [1:0] OpLas = 2'b01;
   localparam logic [1:0] OpRls = 2'b10;
   localparam logic [1:0] OpRas = 2'b11;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             of_q, of_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State register plus datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         y_q     <= '0;
         of_q    <= 1'b0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         of_q    <= of_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; start is only looked at while idle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = (bus.amt != '0) ? StShift : StDone;
            end
         end
         StShift: begin
            if (cnt_q == AMT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: capture on accept, one-bit shift per SHIFT cycle
   always_comb begin
      y_d   = y_q;
      of_d  = of_q;
      cnt_d = cnt_q;
      op_d  = op_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               y_d   = bus.A;
               op_d  = bus.op;
               cnt_d = bus.amt;
               of_d  = 1'b0;
            end
         end
         StShift: begin
            cnt_d = cnt_q - AMT_W'(1);
            unique case (op_q)
               OpLls: begin
                  y_d  = {y_q[WIDTH-2:0], 1'b0};
                  of_d = of_q | y_q[WIDTH-1];
               end
               OpLas: begin
                  y_d  = {y_q[WIDTH-2:0], 1'b0};
                  // Overflow when the sign bit would change
                  of_d = of_q | (y_q[WIDTH-1] ^ y_q[WIDTH-2]);
               end
               OpRls:   y_d = {1'b0, y_q[WIDTH-1:1]};
               OpRas:   y_d = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
               default: y_d = y_q;
            endcase
         end
         default: ;
      endcase
   end

   // Output decode from the next state so busy/done come straight from flops
   always_comb begin
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Y    = y_q;
   assign bus.OF   = of_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: latency, results, busy-ignore and mid-shift reset.
module tb_iterative_shifter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   iterative_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

   iterative_shifter #(.WIDTH(16), .AMT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance edge by edge until done is seen; cyc = edges waited (40 if never seen)
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Issue one request at the next edge and check latency, result and pulse shape
   task automatic run(input string tag, input logic [1:0] o, input logic [15:0] a,
                      input logic [3:0] n, input logic [15:0] ey, input logic eof);
      int cyc;
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.amt   = n;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = 16'hDEAD;
      bus.op    = ~o;
      bus.amt   = 4'hF;
      chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      wait_done(cyc);
      chk({tag, " latency"}, 32'(cyc), 32'(n));
      chk({tag, " Y"}, 32'(bus.Y), 32'(ey));
      chk({tag, " OF"}, 32'(bus.OF), 32'(eof));
      @(posedge clk);
      #1;
      chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
      chk({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
      chk({tag, " Y_held"}, 32'(bus.Y), 32'(ey));
   endtask

   initial begin
      int cyc;
      int done_seen;
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = 16'h0000;
      bus.amt   = 4'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset Y", 32'(bus.Y), 32'd0);
      chk("reset OF", 32'(bus.OF), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed shifts
      run("lls1", 2'b00, 16'h4001, 4'd1, 16'h8002, 1'b0);
      run("lls2", 2'b00, 16'h4001, 4'd2, 16'h0004, 1'b1);
      run("lls15", 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0);
      run("las1", 2'b01, 16'h4000, 4'd1, 16'h8000, 1'b1);
      run("ras4", 2'b11, 16'h8010, 4'd4, 16'hF801, 1'b0);
      run("rls4", 2'b10, 16'h8010, 4'd4, 16'h0801, 1'b0);
      run("amt0", 2'b00, 16'h1234, 4'd0, 16'h1234, 1'b0);

      // Start while busy is ignored
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.A     = 16'hFFFF;
      bus.amt   = 4'd8;
      @(posedge clk);              // edge k
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);   // edges k+1, k+2
      #1;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.A     = 16'h0000;
      bus.amt   = 4'd3;
      @(posedge clk);              // edge k+3
      #1;
      bus.start = 1'b0;
      wait_done(cyc);
      chk("ignore latency", 32'(cyc), 32'd5);
      chk("ignore Y", 32'(bus.Y), 32'h00FF);
      chk("ignore OF", 32'(bus.OF), 32'd0);
      @(posedge clk);              // edge k+9
      #1;
      run("after_ignore", 2'b00, 16'h0003, 4'd1, 16'h0006, 1'b0);

      // Reset in the middle of a shift discards the operation
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.A     = 16'hFFFF;
      bus.amt   = 4'd10;
      @(posedge clk);              // edge k
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midreset busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);              // edge k+4
      #1;
      rst_n = 1'b1;
      chk("midreset busy", 32'(bus.busy), 32'd0);
      chk("midreset Y", 32'(bus.Y), 32'd0);
      chk("midreset OF", 32'(bus.OF), 32'd0);
      chk("midreset done", 32'(bus.done), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) done_seen++;
      end
      chk("midreset no_done", 32'(done_seen), 32'd0);
      run("after_reset", 2'b00, 16'h0003, 4'd1, 16'h0006, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
